// File: rtl/riscv_core_mul_seq_if.sv
// Request/response bundle for the sequential RISC-V multiplier.
// The requester drives the master modport, the multiplier sits on the slave modport.
interface riscv_core_mul_seq_if #(
    parameter int XLEN = 64
) ();
    logic            i_mul_valid;
    logic            o_mul_ready;
    logic [1:0]      i_mul_op;
    logic            i_mul_word;
    logic [XLEN-1:0] i_mul_rs1;
    logic [XLEN-1:0] i_mul_rs2;
    logic            i_mul_flush;
    logic            o_mul_valid;
    logic            i_mul_out_ready;
    logic [XLEN-1:0] o_mul_result;

    modport master (
        output i_mul_valid, i_mul_op, i_mul_word, i_mul_rs1, i_mul_rs2,
        output i_mul_flush, i_mul_out_ready,
        input  o_mul_ready, o_mul_valid, o_mul_result
    );

    modport slave (
        input  i_mul_valid, i_mul_op, i_mul_word, i_mul_rs1, i_mul_rs2,
        input  i_mul_flush, i_mul_out_ready,
        output o_mul_ready, o_mul_valid, o_mul_result
    );
endinterface

// File: rtl/riscv_core_mul_seq.sv
// Sequential radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU and MULW.
// Operands are widened to XLEN+2 bits so a single signed Booth engine covers
// every signedness combination; one Booth digit is retired per BUSY cycle.
module riscv_core_mul_seq #(
    parameter int XLEN      = 64,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic                 i_mul_clk,
    input  logic                 i_mul_rstn,
    riscv_core_mul_seq_if.slave  mul_if
);
    localparam int W    = XLEN + 2;
    localparam int ITER = W / 2;
    localparam int CW   = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [2*W-1:0]    acc_q;
    logic [W-1:0]      m_q;
    logic              qm1_q;
    logic [1:0]        op_q;
    logic              word_q;
    logic [XLEN-1:0]   result_q;
    logic              valid_q;

    logic [W-1:0]      a_ext_s;
    logic [W-1:0]      b_ext_s;
    logic              accept_s;
    logic              zero_s;
    logic              last_s;
    logic [W+1:0]      m_x_s;
    logic [W+1:0]      pp_s;
    logic [W+1:0]      sum_s;
    logic [2*W-1:0]    acc_step_s;
    logic              ready_s;

    // Select MUL low half, high half, or sign-extended low word of the product.
    function automatic logic [XLEN-1:0] pick_result(input logic [2*W-1:0] prod,
                                                    input logic [1:0]     op,
                                                    input logic           word);
        logic [XLEN-1:0] r;
        if (word) begin
            r = XLEN'($signed(prod[31:0]));
        end else if (op == 2'b00) begin
            r = prod[XLEN-1:0];
        end else begin
            r = prod[2*XLEN-1:XLEN];
        end
        return r;
    endfunction

    // Widen request operands according to opcode signedness or word mode.
    always_comb begin
        a_ext_s = {2'b00, mul_if.i_mul_rs1};
        b_ext_s = {2'b00, mul_if.i_mul_rs2};
        if (mul_if.i_mul_word) begin
            a_ext_s = W'($signed(mul_if.i_mul_rs1[31:0]));
            b_ext_s = W'($signed(mul_if.i_mul_rs2[31:0]));
        end else begin
            case (mul_if.i_mul_op)
                2'b01: begin
                    a_ext_s = {{2{mul_if.i_mul_rs1[XLEN-1]}}, mul_if.i_mul_rs1};
                    b_ext_s = {{2{mul_if.i_mul_rs2[XLEN-1]}}, mul_if.i_mul_rs2};
                end
                2'b10: begin
                    a_ext_s = {{2{mul_if.i_mul_rs1[XLEN-1]}}, mul_if.i_mul_rs1};
                end
                default: begin
                    a_ext_s = {2'b00, mul_if.i_mul_rs1};
                end
            endcase
        end
    end

    assign accept_s = (state_q == ST_IDLE) && mul_if.i_mul_valid;
    assign zero_s   = EARLY_OUT && ((a_ext_s == '0) || (b_ext_s == '0));
    assign last_s   = (cnt_q == CW'(1));

    // One Booth step: pick the partial product from {y[i+1], y[i], y[i-1]} and shift by two.
    always_comb begin
        m_x_s = {{2{m_q[W-1]}}, m_q};
        case ({acc_q[1:0], qm1_q})
            3'b001, 3'b010: pp_s = m_x_s;
            3'b011:         pp_s = m_x_s << 1;
            3'b100:         pp_s = -(m_x_s << 1);
            3'b101, 3'b110: pp_s = -m_x_s;
            default:        pp_s = '0;
        endcase
        sum_s      = {{2{acc_q[2*W-1]}}, acc_q[2*W-1:W]} + pp_s;
        acc_step_s = {sum_s, acc_q[W-1:2]};
    end

    // FSM state register.
    always_ff @(posedge i_mul_clk or negedge i_mul_rstn) begin
        if (!i_mul_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: flush wins over completion and consumption.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (mul_if.i_mul_valid) begin
                    state_d = zero_s ? ST_DONE : ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (mul_if.i_mul_flush) begin
                    state_d = ST_IDLE;
                end else if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (mul_if.i_mul_flush || mul_if.i_mul_out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: ready depends on state only.
    always_comb begin
        ready_s = 1'b0;
        if (state_q == ST_IDLE) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    // Datapath: capture operands on accept, iterate while busy, latch the result on completion.
    always_ff @(posedge i_mul_clk or negedge i_mul_rstn) begin
        if (!i_mul_rstn) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            m_q      <= '0;
            qm1_q    <= 1'b0;
            op_q     <= 2'b00;
            word_q   <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= (state_d == ST_DONE);
            if (accept_s) begin
                m_q    <= a_ext_s;
                acc_q  <= {{W{1'b0}}, b_ext_s};
                qm1_q  <= 1'b0;
                cnt_q  <= CW'(ITER);
                op_q   <= mul_if.i_mul_op;
                word_q <= mul_if.i_mul_word;
                if (zero_s) begin
                    result_q <= '0;
                end else begin
                    result_q <= result_q;
                end
            end else if ((state_q == ST_BUSY) && !mul_if.i_mul_flush) begin
                acc_q <= acc_step_s;
                qm1_q <= acc_q[1];
                cnt_q <= cnt_q - CW'(1);
                if (last_s) begin
                    result_q <= pick_result(acc_step_s, op_q, word_q);
                end else begin
                    result_q <= result_q;
                end
            end else begin
                acc_q    <= acc_q;
                result_q <= result_q;
            end
        end
    end

    assign mul_if.o_mul_ready  = ready_s;
    assign mul_if.o_mul_valid  = valid_q;
    assign mul_if.o_mul_result = result_q;

endmodule
